// File: rtl/gpio_switch_led_if.sv
// CPU-side bus of the GPIO switch/LED peripheral: single-cycle request, one-cycle ack.
interface gpio_switch_led_if;
    logic        bus_req;
    logic        bus_we;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );
endinterface

// File: rtl/gpio_switch_led.sv
// GPIO peripheral: synchronised and debounced slide switches with sticky edge flags and a
// maskable level interrupt, plus a CPU-writable LED register.
// Map: 0x00 SW_STATE (RO), 0x04 LED (RW), 0x08 PENDING (W1C), 0x0C IRQ_EN (RW).
module gpio_switch_led #(
    parameter int unsigned NUM_SW          = 4,
    parameter int unsigned NUM_LED         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SW-1:0]  switch_in,
    output logic [NUM_LED-1:0] led_out,
    output logic               irq,
    gpio_switch_led_if.slave   bus
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SW-1:0]  meta_q;
    logic [NUM_SW-1:0]  sync_q;
    logic [NUM_SW-1:0]  stable_q;
    logic [NUM_SW-1:0]  pending_q;
    logic [NUM_SW-1:0]  pending_d;
    logic [NUM_SW-1:0]  irq_en_q;
    logic [NUM_SW-1:0]  irq_en_d;
    logic [NUM_SW-1:0]  accept;
    logic [NUM_SW-1:0]  clr_mask;
    logic [NUM_LED-1:0] led_q;
    logic [NUM_LED-1:0] led_d;
    logic [CNT_W-1:0]   cnt_q [NUM_SW];
    logic [CNT_W-1:0]   cnt_d [NUM_SW];

    logic        wr_en;
    logic        rd_en;
    logic [5:0]  reg_idx;
    logic [31:0] rd_val;
    logic        ack_q;
    logic [31:0] rdata_q;

    // Byte-lane bits and surplus write-data bits carry no meaning for this block.
    logic unused_bus;
    assign unused_bus = ^{bus.bus_addr[1:0], bus.bus_wdata};

    assign wr_en   = bus.bus_req & bus.bus_we;
    assign rd_en   = bus.bus_req & ~bus.bus_we;
    assign reg_idx = bus.bus_addr[7:2];

    // Two-flop synchroniser for the raw switch pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= switch_in;
            sync_q <= meta_q;
        end
    end

    // Per-bit debounce: count consecutive disagreeing cycles, accept on the last one.
    always_comb begin
        accept = '0;
        for (int i = 0; i < int'(NUM_SW); i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    accept[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounced state and counters; an accepted bit simply toggles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q <= '0;
            for (int i = 0; i < int'(NUM_SW); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_q ^ accept;
            for (int i = 0; i < int'(NUM_SW); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Register writes; a new edge overrides a simultaneous W1C of the same bit.
    always_comb begin
        led_d    = led_q;
        irq_en_d = irq_en_q;
        clr_mask = '0;
        if (wr_en) begin
            case (reg_idx)
                6'd1:    led_d    = bus.bus_wdata[NUM_LED-1:0];
                6'd2:    clr_mask = bus.bus_wdata[NUM_SW-1:0];
                6'd3:    irq_en_d = bus.bus_wdata[NUM_SW-1:0];
                default: ;
            endcase
        end
        pending_d = (pending_q & ~clr_mask) | accept;
    end

    // Software-visible registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q     <= '0;
            irq_en_q  <= '0;
            pending_q <= '0;
        end else begin
            led_q     <= led_d;
            irq_en_q  <= irq_en_d;
            pending_q <= pending_d;
        end
    end

    // Read mux over pre-update register contents; unmapped addresses read 0.
    always_comb begin
        rd_val = '0;
        case (reg_idx)
            6'd0:    rd_val[NUM_SW-1:0]  = stable_q;
            6'd1:    rd_val[NUM_LED-1:0] = led_q;
            6'd2:    rd_val[NUM_SW-1:0]  = pending_q;
            6'd3:    rd_val[NUM_SW-1:0]  = irq_en_q;
            default: rd_val = '0;
        endcase
    end

    // Ack exactly one cycle after each request; rdata is zero outside read acks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= bus.bus_req;
            rdata_q <= rd_en ? rd_val : 32'd0;
        end
    end

    assign bus.bus_ack   = ack_q;
    assign bus.bus_rdata = rdata_q;
    assign led_out       = led_q;
    assign irq           = |(pending_q & irq_en_q);

endmodule

// File: tb/tb_gpio_switch_led.sv
// Bench for gpio_switch_led: directed steps followed by a random phase, all checked
// every cycle against a pin-history reference model of the peripheral.
module tb_gpio_switch_led;
    localparam int DB   = 4;
    localparam int HMAX = 8192;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] sw    = 4'h0;
    logic [3:0] led;
    logic       irq;

    int tests = 0;
    int fails = 0;

    gpio_switch_led_if bus_if ();

    gpio_switch_led #(
        .NUM_SW         (4),
        .NUM_LED        (4),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .switch_in(sw),
        .led_out  (led),
        .irq      (irq),
        .bus      (bus_if)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: pin value sampled at every active edge, indexed by edge number.
    logic [3:0]  hist [HMAX];
    int          e;
    int          last_flip [4];
    logic [3:0]  m_stable, m_pend, m_en, m_led;
    logic        m_ack;
    logic [31:0] m_rdata;

    // A bit is accepted at edge k when the pin values that reach the debouncer in the
    // DB evaluations ending at k all differ from the accepted value, none before the
    // previous acceptance (pins take two edges to reach the debouncer).
    function automatic logic [3:0] flips_at(input int k);
        logic [3:0] f;
        logic       all_diff;
        f = 4'h0;
        for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int j = k - DB - 1; j <= k - 2; j++) begin
                if (hist[j][i] == m_stable[i]) all_diff = 1'b0;
            end
            if (all_diff && (k - DB + 1 > last_flip[i])) f[i] = 1'b1;
        end
        return f;
    endfunction

    function automatic logic [31:0] reg_read(input logic [7:0] addr);
        case (addr[7:2])
            6'd0:    return {28'd0, m_stable};
            6'd1:    return {28'd0, m_led};
            6'd2:    return {28'd0, m_pend};
            6'd3:    return {28'd0, m_en};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        e = 5;
        for (int j = 0; j <= 5; j++) hist[j] = 4'h0;
        for (int i = 0; i < 4; i++) last_flip[i] = 5;
        m_stable = 4'h0;
        m_pend   = 4'h0;
        m_en     = 4'h0;
        m_led    = 4'h0;
        m_ack    = 1'b0;
        m_rdata  = 32'd0;
    endtask

    task automatic model_edge(input logic [3:0] pin, input logic req, input logic we,
                              input logic [7:0] addr, input logic [31:0] wdata);
        logic [3:0] fl;
        logic [3:0] clr;
        e       = e + 1;
        hist[e] = pin;
        fl      = flips_at(e);
        clr     = 4'h0;
        m_ack   = req;
        m_rdata = (req && !we) ? reg_read(addr) : 32'd0;
        if (req && we) begin
            case (addr[7:2])
                6'd1:    m_led = wdata[3:0];
                6'd2:    clr   = wdata[3:0];
                6'd3:    m_en  = wdata[3:0];
                default: ;
            endcase
        end
        m_pend   = (m_pend & ~clr) | fl;
        m_stable = m_stable ^ fl;
        for (int i = 0; i < 4; i++) if (fl[i]) last_flip[i] = e;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One active edge with the model advanced, then all outputs compared.
    task automatic tick();
        logic [3:0]  pin;
        logic        req, we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        pin   = sw;
        req   = bus_if.bus_req;
        we    = bus_if.bus_we;
        addr  = bus_if.bus_addr;
        wdata = bus_if.bus_wdata;
        @(posedge clk);
        model_edge(pin, req, we, addr, wdata);
        #1;
        check("led_out", {28'd0, led}, {28'd0, m_led});
        check("irq", {31'd0, irq}, {31'd0, |(m_pend & m_en)});
        check("bus_ack", {31'd0, bus_if.bus_ack}, {31'd0, m_ack});
        check("bus_rdata", bus_if.bus_rdata, m_rdata);
    endtask

    // Edge while held in reset: everything must read zero.
    task automatic tick_rst();
        @(posedge clk);
        #1;
        check("rst_led", {28'd0, led}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ack", {31'd0, bus_if.bus_ack}, 32'd0);
        check("rst_rdata", bus_if.bus_rdata, 32'd0);
    endtask

    task automatic bus_op(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd);
        bus_if.bus_req   = 1'b1;
        bus_if.bus_we    = we;
        bus_if.bus_addr  = addr;
        bus_if.bus_wdata = wdata;
        tick();
        check("op_ack", {31'd0, bus_if.bus_ack}, 32'd1);
        rd = bus_if.bus_rdata;
        bus_if.bus_req = 1'b0;
    endtask

    function automatic logic [7:0] rnd_addr();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'h04;
            2:       return 8'h08;
            3:       return 8'h0C;
            4:       return 8'(8'h10 + 4 * $urandom_range(0, 59));
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] rd;
        logic [3:0]  fl;
        logic        found;

        bus_if.bus_req   = 1'b0;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_addr  = 8'h00;
        bus_if.bus_wdata = 32'd0;
        model_reset();

        // Reset held with random pins and bus traffic.
        for (int n = 0; n < 8; n++) begin
            sw               = 4'($urandom);
            bus_if.bus_req   = 1'($urandom);
            bus_if.bus_we    = 1'($urandom);
            bus_if.bus_addr  = rnd_addr();
            bus_if.bus_wdata = $urandom;
            tick_rst();
        end
        sw             = 4'h0;
        bus_if.bus_req = 1'b0;
        reset          = 1'b1;
        model_reset();
        for (int n = 0; n < 5; n++) tick();

        // Switch 0 step, accepted after debounce; IRQ_EN still 0.
        sw = 4'h1;
        for (int n = 0; n < 6; n++) tick();
        bus_op(1'b0, 8'h00, 32'd0, rd);
        check("sw_state_bit0", rd, 32'h1);
        bus_op(1'b0, 8'h08, 32'd0, rd);
        check("pending_bit0", rd, 32'h1);
        check("irq_masked", {31'd0, irq}, 32'd0);

        // Short glitch on switch 1 is rejected.
        sw = 4'h3;
        for (int n = 0; n < 3; n++) tick();
        sw = 4'h1;
        for (int n = 0; n < 8; n++) tick();
        bus_op(1'b0, 8'h00, 32'd0, rd);
        check("glitch_sw_state", rd, 32'h1);
        bus_op(1'b0, 8'h08, 32'd0, rd);
        check("glitch_pending", rd, 32'h1);
        check("glitch_irq", {31'd0, irq}, 32'd0);

        // LED write visible in the ack cycle, readback, back-to-back reads.
        tick();
        bus_op(1'b1, 8'h04, 32'hFFFF_FFFA, rd);
        check("led_in_ack", {28'd0, led}, 32'hA);
        tick();
        bus_op(1'b0, 8'h04, 32'd0, rd);
        check("led_readback", rd, 32'hA);
        bus_op(1'b0, 8'h00, 32'd0, rd);
        check("b2b_first", rd, 32'h1);
        bus_op(1'b0, 8'h04, 32'd0, rd);
        check("b2b_second", rd, 32'hA);
        tick();

        // Interrupt enable, W1C, and clear colliding with a new edge.
        bus_op(1'b1, 8'h0C, 32'h1, rd);
        check("irq_enabled", {31'd0, irq}, 32'd1);
        bus_op(1'b1, 8'h08, 32'h1, rd);
        check("irq_w1c", {31'd0, irq}, 32'd0);
        sw    = 4'h0;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            if (irq === 1'b1) found = 1'b1;
        end
        check("irq_after_toggle", {31'd0, irq}, 32'd1);
        bus_op(1'b1, 8'h08, 32'h1, rd);
        check("irq_w1c_again", {31'd0, irq}, 32'd0);
        sw    = 4'h1;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            fl = flips_at(e + 1);
            if (fl[0]) found = 1'b1;
            else tick();
        end
        check("flip_wait", {31'd0, found}, 32'd1);
        bus_op(1'b1, 8'h08, 32'h1, rd);
        check("set_beats_clear_irq", {31'd0, irq}, 32'd1);
        bus_op(1'b0, 8'h08, 32'd0, rd);
        check("set_beats_clear_pend", rd, 32'h1);

        // Unmapped read, then reset during an access.
        bus_op(1'b0, 8'h14, 32'd0, rd);
        check("unmapped_read", rd, 32'h0);
        bus_if.bus_req  = 1'b1;
        bus_if.bus_we   = 1'b0;
        bus_if.bus_addr = 8'h04;
        #2;
        reset = 1'b0;
        #1;
        check("reset_async_led", {28'd0, led}, 32'd0);
        for (int n = 0; n < 3; n++) tick_rst();
        bus_if.bus_req = 1'b0;
        reset          = 1'b1;
        model_reset();
        bus_op(1'b0, 8'h04, 32'd0, rd);
        check("post_rst_led", rd, 32'h0);
        bus_op(1'b0, 8'h0C, 32'd0, rd);
        check("post_rst_irq_en", rd, 32'h0);
        bus_op(1'b0, 8'h08, 32'd0, rd);
        check("post_rst_pending", rd, 32'h0);

        // Random pins and bus traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) sw[b] = ~sw[b];
            bus_if.bus_req   = 1'($urandom);
            bus_if.bus_we    = 1'($urandom);
            bus_if.bus_addr  = rnd_addr();
            bus_if.bus_wdata = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
